// File: rtl/hvac_zone_scheduler.sv
// hvac_zone_scheduler
//   Time-shares one heating/cooling plant among NUM_ZONES zones. Each zone
//   raises a heat or cool request from its own 5-bit temperature using fixed
//   hysteresis thresholds. A round-robin arbiter grants the plant to one zone
//   at a time. Each grant has a minimum run length and a maximum dwell, after
//   which another requester preempts it. Every run is followed by a
//   plant-off guard interval.
//
// Ports
//   clk          system clock, rising edge
//   rst          synchronous active-high reset
//   enable       plant enable; low blocks new grants and aborts a running grant
//   zone_temp    packed temperatures, zone i at [5i+4:5i]
//   heating      plant heat enable (registered)
//   cooling      plant cool enable (registered)
//   damper       one-hot open damper, zero while the plant is off (registered)
//   active_zone  granted zone index; holds its last value while idle

// Per-zone threshold decode: request and satisfaction flags for one sensor.
module hvac_zone_req #(
    parameter logic [4:0] HEAT_ON = 5'd18,
    parameter logic [4:0] COOL_ON = 5'd22,
    parameter logic [4:0] TARGET  = 5'd20
) (
    input  logic [4:0] temp,
    output logic       heat_req,
    output logic       cool_req,
    output logic       heat_sat,
    output logic       cool_sat
);
    assign heat_req = (temp <= HEAT_ON);
    assign cool_req = (temp >= COOL_ON);
    assign heat_sat = (temp >= TARGET);
    assign cool_sat = (temp <= TARGET);
endmodule

module hvac_zone_scheduler #(
    parameter int         NUM_ZONES    = 4,
    parameter logic [4:0] HEAT_ON      = 5'd18,
    parameter logic [4:0] COOL_ON      = 5'd22,
    parameter logic [4:0] TARGET       = 5'd20,
    parameter int         MIN_RUN      = 4,
    parameter int         MAX_RUN      = 16,
    parameter int         GUARD_CYCLES = 3
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   enable,
    input  logic [5*NUM_ZONES-1:0] zone_temp,
    output logic                   heating,
    output logic                   cooling,
    output logic [NUM_ZONES-1:0]   damper,
    output logic [2:0]             active_zone
);
    localparam int RW = $clog2(MAX_RUN + 1);
    localparam int GW = $clog2(GUARD_CYCLES + 1);
    localparam logic [RW-1:0] MIN_C   = RW'(MIN_RUN);
    localparam logic [RW-1:0] MAX_C   = RW'(MAX_RUN);
    localparam logic [GW-1:0] GUARD_C = GW'(GUARD_CYCLES);
    localparam logic [2:0]    LAST_Z  = 3'(NUM_ZONES - 1);

    typedef enum logic [1:0] {IDLE, HEAT, COOL, GUARD} state_t;

    typedef struct packed {
        logic       found;
        logic [2:0] idx;
    } grant_t;

    state_t                       state, state_n;
    logic [NUM_ZONES-1:0][4:0]    temp;
    logic [NUM_ZONES-1:0]         heat_req, cool_req, heat_sat, cool_sat;
    // Zero-padded to 8 so a 3-bit zone index selects them for any NUM_ZONES.
    logic [7:0]                   req8, hreq8, hsat8, csat8;
    logic [2:0]                   ptr, ptr_n, zone_n;
    logic [RW-1:0]                run_cnt, run_n;
    logic [GW-1:0]                guard_cnt, guard_n;
    logic                         heat_n, cool_n, sat, other_req;
    logic [NUM_ZONES-1:0]         damper_n, grant_oh;
    grant_t                       grant;

    assign temp = zone_temp;

    generate
        for (genvar i = 0; i < NUM_ZONES; i++) begin : g_zone
            hvac_zone_req #(
                .HEAT_ON(HEAT_ON),
                .COOL_ON(COOL_ON),
                .TARGET (TARGET)
            ) u_req (
                .temp    (temp[i]),
                .heat_req(heat_req[i]),
                .cool_req(cool_req[i]),
                .heat_sat(heat_sat[i]),
                .cool_sat(cool_sat[i])
            );
        end
    endgenerate

    assign req8  = 8'(heat_req | cool_req);
    assign hreq8 = 8'(heat_req);
    assign hsat8 = 8'(heat_sat);
    assign csat8 = 8'(cool_sat);

    // Round-robin scan from ptr. Walking the offsets from far to near lets
    // the nearest requester win without an early exit.
    always_comb begin
        logic [3:0] s;
        grant = '0;
        s     = '0;
        for (int off = NUM_ZONES - 1; off >= 0; off--) begin
            s = 4'(ptr) + 4'(off);
            if (s >= 4'(NUM_ZONES)) s = s - 4'(NUM_ZONES);
            if (req8[s[2:0]]) begin
                grant.found = 1'b1;
                grant.idx   = s[2:0];
            end
        end
    end

    always_comb begin
        grant_oh = '0;
        for (int i = 0; i < NUM_ZONES; i++) grant_oh[i] = (3'(i) == grant.idx);
    end

    // The mode is fixed at grant time, so satisfaction is judged against
    // the granted mode even if the zone has drifted into the opposite band.
    assign sat       = (state == HEAT) ? hsat8[active_zone] : csat8[active_zone];
    assign other_req = |(req8 & ~(8'd1 << active_zone));

    always_comb begin
        state_n  = state;
        heat_n   = heating;
        cool_n   = cooling;
        damper_n = damper;
        zone_n   = active_zone;
        ptr_n    = ptr;
        run_n    = run_cnt;
        guard_n  = guard_cnt;
        case (state)
            IDLE: begin
                if (enable && grant.found) begin
                    state_n  = hreq8[grant.idx] ? HEAT : COOL;
                    heat_n   = hreq8[grant.idx];
                    cool_n   = ~hreq8[grant.idx];
                    damper_n = grant_oh;
                    zone_n   = grant.idx;
                    run_n    = RW'(1);
                end
            end
            HEAT, COOL: begin
                if (!enable || (sat && run_cnt >= MIN_C) ||
                    (run_cnt >= MAX_C && other_req)) begin
                    state_n  = GUARD;
                    heat_n   = 1'b0;
                    cool_n   = 1'b0;
                    damper_n = '0;
                    ptr_n    = (active_zone == LAST_Z) ? 3'd0 : active_zone + 3'd1;
                    guard_n  = GW'(1);
                end else if (run_cnt != MAX_C) begin
                    run_n = run_cnt + RW'(1);
                end
            end
            GUARD: begin
                if (guard_cnt == GUARD_C) state_n = IDLE;
                else                      guard_n = guard_cnt + GW'(1);
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            heating     <= 1'b0;
            cooling     <= 1'b0;
            damper      <= '0;
            active_zone <= 3'd0;
            ptr         <= 3'd0;
            run_cnt     <= '0;
            guard_cnt   <= '0;
        end else begin
            state       <= state_n;
            heating     <= heat_n;
            cooling     <= cool_n;
            damper      <= damper_n;
            active_zone <= zone_n;
            ptr         <= ptr_n;
            run_cnt     <= run_n;
            guard_cnt   <= guard_n;
        end
    end
endmodule

// File: tb/tb_hvac_zone_scheduler.sv
// Self-checking bench for hvac_zone_scheduler: directed scenarios with
// literal expectations, plus a per-cycle reference model of the scheduling
// rules (grant / run length / off time).
module tb_hvac_zone_scheduler;
    localparam int N       = 4;
    localparam int MINR    = 4;
    localparam int MAXR    = 16;
    localparam int GUARD   = 3;

    logic             clk = 1'b0;
    logic             rst, enable;
    logic [5*N-1:0]   zone_temp;
    logic             heating, cooling;
    logic [N-1:0]     damper;
    logic [2:0]       active_zone;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    hvac_zone_scheduler #(
        .NUM_ZONES(N), .MIN_RUN(MINR), .MAX_RUN(MAXR), .GUARD_CYCLES(GUARD)
    ) dut (
        .clk(clk), .rst(rst), .enable(enable), .zone_temp(zone_temp),
        .heating(heating), .cooling(cooling), .damper(damper),
        .active_zone(active_zone)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int tz(input int z);
        return int'(zone_temp[5*z +: 5]);
    endfunction

    function automatic bit zreq(input int z);
        return (tz(z) <= 18) || (tz(z) >= 22);
    endfunction

    // Reference model. The plant is either on for one zone (run length
    // counted in cycles) or off (age counted in edges since it stopped).
    // A new grant may be decided once the plant has been off for
    // GUARD+1 edges. Reset clears everything and allows an immediate grant.
    bit m_on, m_heat;
    int m_zone, m_ptr, m_run, m_off;

    always @(posedge clk) begin
        bit sat, other;
        int z;
        if (rst) begin
            m_on = 0; m_heat = 0; m_zone = 0; m_ptr = 0; m_run = 0; m_off = 1000;
        end else if (m_on) begin
            sat   = m_heat ? (tz(m_zone) >= 20) : (tz(m_zone) <= 20);
            other = 0;
            for (int j = 0; j < N; j++) if (j != m_zone && zreq(j)) other = 1;
            if (!enable || (sat && m_run >= MINR) || (m_run >= MAXR && other)) begin
                m_on  = 0;
                m_ptr = (m_zone + 1) % N;
                m_off = 0;
            end else begin
                m_run++;
            end
        end else begin
            if (m_off < 1000) m_off++;
            if (m_off >= GUARD + 1 && enable) begin
                for (int o = 0; o < N; o++) begin
                    z = (m_ptr + o) % N;
                    if (!m_on && zreq(z)) begin
                        m_on = 1; m_zone = z; m_heat = (tz(z) <= 18); m_run = 1;
                    end
                end
            end
        end
        #1;
        chk("model_heating", heating, m_on && m_heat);
        chk("model_cooling", cooling, m_on && !m_heat);
        chk("model_damper", damper, m_on ? (32'd1 << m_zone) : 32'd0);
        chk("model_active_zone", active_zone, m_zone);
    end

    task automatic set_t(input int z, input logic [4:0] v);
        zone_temp[5*z +: 5] = v;
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Waits (bounded) until the requested plant output is high.
    task automatic wait_on(input string name, input bit want_cool);
        int n = 0;
        while (!(want_cool ? cooling : heating) && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk(name, n < 40, 1);
    endtask

    initial begin
        int n;
        rst = 1'b1; enable = 1'b1;
        for (int i = 0; i < N; i++) set_t(i, 5'd20);
        cyc(2);
        // Reset state
        chk("rst_heating", heating, 0);
        chk("rst_cooling", cooling, 0);
        chk("rst_damper", damper, 0);
        chk("rst_zone", active_zone, 0);
        rst = 1'b0;

        // 1: all zones at 20, nothing happens
        cyc(50);
        chk("t1_heating", heating, 0);
        chk("t1_damper", damper, 0);

        // 2: zone2 heat, satisfied early, runs exactly MIN_RUN
        set_t(2, 5'd17);
        @(negedge clk);
        chk("t2_heat_on", heating, 1);
        chk("t2_damper", damper, 4'b0100);
        chk("t2_zone", active_zone, 2);
        @(negedge clk);
        set_t(2, 5'd21);
        cyc(2);
        chk("t2_heat_run4", heating, 1);
        @(negedge clk);
        chk("t2_heat_off", heating, 0);
        chk("t2_damper_off", damper, 0);
        cyc(6);

        // 3: pointer back to 0, zone1 cool beats zone3 heat
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        set_t(1, 5'd23);
        set_t(3, 5'd15);
        @(negedge clk);
        chk("t3_cool_on", cooling, 1);
        chk("t3_damper_z1", damper, 4'b0010);
        set_t(1, 5'd20);
        cyc(7);
        chk("t3_idle_gap", heating | cooling, 0);
        @(negedge clk);
        chk("t3_heat_on", heating, 1);
        chk("t3_damper_z3", damper, 4'b1000);
        set_t(3, 5'd20);
        cyc(12);

        // 4: contention, MAX_RUN preemption and alternation
        set_t(0, 5'd16);
        set_t(1, 5'd24);
        wait_on("t4_heat_start", 0);
        n = 0;
        while (heating && n < 40) begin n++; @(negedge clk); end
        chk("t4_heat_len", n, 16);
        n = 0;
        while (!cooling && n < 40) begin n++; @(negedge clk); end
        chk("t4_off_len", n, 4);
        chk("t4_damper_z1", damper, 4'b0010);
        cyc(40);
        set_t(0, 5'd20);
        set_t(1, 5'd20);
        cyc(25);

        // 5: enable drop aborts a run before MIN_RUN
        set_t(0, 5'd16);
        wait_on("t5_heat_start", 0);
        @(negedge clk);
        enable = 1'b0;
        @(negedge clk);
        chk("t5_abort", heating, 0);
        cyc(20);
        chk("t5_no_grant", heating, 0);
        chk("t5_no_damper", damper, 0);
        enable = 1'b1;
        set_t(0, 5'd20);
        cyc(10);

        // 6: reset mid-cool, then scanning restarts at zone 0
        set_t(3, 5'd25);
        wait_on("t6_cool_start", 1);
        chk("t6_damper_z3", damper, 4'b1000);
        cyc(2);
        set_t(1, 5'd15);
        rst = 1'b1;
        @(negedge clk);
        chk("t6_rst_cool", cooling, 0);
        chk("t6_rst_damper", damper, 0);
        chk("t6_rst_zone", active_zone, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("t6_heat_z1", heating, 1);
        chk("t6_damper_z1", damper, 4'b0010);
        chk("t6_zone", active_zone, 1);
        for (int i = 0; i < N; i++) set_t(i, 5'd20);
        cyc(25);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
